seq_divider: RTL and testbench

//  Multicycle restoring divider for the MIPS datapath; serves DIV (and DIVU when enabled).

---
 rtl/seq_divider.sv | 151 +++++++++++++++
 tb/tb_seq_divider.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider
// Description : Multicycle restoring divider (MIPS DIV, optional DIVU via
//               SEQ_DIVIDER_UNSIGNED_EN); quotient -> LO, remainder -> HI.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SEQ_DIVIDER_UNSIGNED_EN
  input  logic             is_unsigned,
`endif
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int              c_CW       = $clog2(WIDTH + 1);
  localparam logic [c_CW-1:0] c_CNT_INIT = c_CW'(WIDTH);
  localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [c_CW-1:0]   r_count;
  logic [WIDTH-1:0]  r_dvd;
  logic [WIDTH-1:0]  r_rem;
  logic [WIDTH-1:0]  r_dvs;
  logic              r_sign_q;
  logic              r_sign_r;
  logic              r_dz;

  logic              w_uns;
  logic              w_b_zero;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [WIDTH-1:0]  w_abs_a;
  logic [WIDTH-1:0]  w_abs_b;
  logic [WIDTH:0]    w_shift;
  logic [WIDTH:0]    w_diff;
  logic              w_ge;

`ifdef SEQ_DIVIDER_UNSIGNED_EN
  assign w_uns = is_unsigned;
`else
  assign w_uns = 1'b0;
`endif

  assign w_b_zero = (b == '0);
  assign w_a_neg  = ~w_uns & a[WIDTH-1];
  assign w_b_neg  = ~w_uns & b[WIDTH-1];
  assign w_abs_a  = w_a_neg ? -a : a;
  assign w_abs_b  = w_b_neg ? -b : b;

  // Partial remainder stays below the divisor, so bit WIDTH of the
  // difference is set exactly when the trial subtraction underflows.
  assign w_shift  = {r_rem, r_dvd[WIDTH-1]};
  assign w_diff   = w_shift - {1'b0, r_dvs};
  assign w_ge     = ~w_diff[WIDTH];

  assign busy     = (r_state == S_RUN) || (r_state == S_FIX);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = w_b_zero ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (r_count == c_CNT_LAST) begin
          w_next = S_FIX;
        end
      end
      S_FIX:   w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count     <= '0;
      r_dvd       <= '0;
      r_rem       <= '0;
      r_dvs       <= '0;
      r_sign_q    <= 1'b0;
      r_sign_r    <= 1'b0;
      r_dz        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done        <= (r_state == S_DONE);
      div_by_zero <= (r_state == S_DONE) && r_dz;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_dz <= w_b_zero;
            if (!w_b_zero) begin
              r_dvd    <= w_abs_a;
              r_dvs    <= w_abs_b;
              r_rem    <= '0;
              r_count  <= c_CNT_INIT;
              r_sign_q <= w_a_neg ^ w_b_neg;
              r_sign_r <= w_a_neg;
            end
          end
        end
        S_RUN: begin
          // Dividend bits shift out the top while quotient bits fill the bottom.
          r_rem   <= w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
          r_dvd   <= {r_dvd[WIDTH-2:0], w_ge};
          r_count <= r_count - c_CNT_LAST;
        end
        S_FIX: begin
          quotient  <= r_sign_q ? -r_dvd : r_dvd;
          remainder <= r_sign_r ? -r_rem : r_rem;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_divider
// Description : Self-checking bench for seq_divider against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_divider;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
`ifdef SEQ_DIVIDER_UNSIGNED_EN
  logic         is_unsigned;
`endif
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_by_zero;

  int           n_vec  = 0;
  int           n_miss = 0;
  logic [W-1:0] last_q = '0;
  logic [W-1:0] last_r = '0;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .a           (a),
    .b           (b),
`ifdef SEQ_DIVIDER_UNSIGNED_EN
    .is_unsigned (is_unsigned),
`endif
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: MIPS semantics from plain 64-bit arithmetic; b==0 keeps prior results.
  function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y,
                                input bit uns, output logic [W-1:0] q,
                                output logic [W-1:0] r);
    longint sx, sy, tq, tr;
    if (y == '0) begin
      q = last_q;
      r = last_r;
      return;
    end
    sx = uns ? longint'({32'h0, x}) : longint'($signed(x));
    sy = uns ? longint'({32'h0, y}) : longint'($signed(y));
    tq = sx / sy;
    tr = sx % sy;
    q  = tq[W-1:0];
    r  = tr[W-1:0];
  endfunction

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input bit hold,
                        output int lat, output int bcnt);
    a     = x;
    b     = y;
    start = 1'b1;
    step();
    if (!hold) start = 1'b0;
    lat  = 0;
    bcnt = (busy === 1'b1) ? 1 : 0;
    while (done !== 1'b1 && lat < 100) begin
      step();
      lat++;
      if (busy === 1'b1) bcnt++;
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
`ifdef SEQ_DIVIDER_UNSIGNED_EN
    is_unsigned = 1'b0;
`endif
    step();
    step();
    reset  = 1'b0;
    last_q = '0;
    last_r = '0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_vec++;
    if ({quotient, remainder, busy, done, div_by_zero} !== {(2*W+3){1'b0}}) begin
      n_miss++;
      $display("FAIL reset_state: got q=%h r=%h busy=%b done=%b dz=%b, expected all zero",
               quotient, remainder, busy, done, div_by_zero);
    end
  endtask

  task automatic test_basic();
    int lat, bc;
    run_op(32'd100, 32'd7, 1'b0, lat, bc);
    n_vec++;
    if (lat !== 34) begin n_miss++; $display("FAIL basic_latency: got %0d expected 34", lat); end
    n_vec++;
    if (bc !== 33) begin n_miss++; $display("FAIL basic_busy_cycles: got %0d expected 33", bc); end
    n_vec++;
    if (quotient !== 32'd14 || remainder !== 32'd2 || div_by_zero !== 1'b0) begin
      n_miss++;
      $display("FAIL basic_result: got q=%0d r=%0d dz=%b expected q=14 r=2 dz=0",
               quotient, remainder, div_by_zero);
    end
    last_q = 32'd14;
    last_r = 32'd2;
    step();
    n_vec++;
    if (done !== 1'b0) begin n_miss++; $display("FAIL basic_done_width: got done=%b expected 0", done); end
  endtask

  task automatic test_signs();
    logic [W-1:0] xs[4] = '{-32'sd7, 32'sd7, -32'sd7, 32'hFFFF_FFFF};
    logic [W-1:0] ys[4] = '{32'sd2, -32'sd2, -32'sd2, 32'h10};
    logic [W-1:0] eq, er;
    int lat, bc;
    for (int i = 0; i < 4; i++) begin
      model(xs[i], ys[i], 1'b0, eq, er);
      run_op(xs[i], ys[i], 1'b0, lat, bc);
      n_vec++;
      if (quotient !== eq || remainder !== er || lat !== 34) begin
        n_miss++;
        $display("FAIL sign_case%0d: got q=%h r=%h lat=%0d expected q=%h r=%h lat=34",
                 i, quotient, remainder, lat, eq, er);
      end
      last_q = eq;
      last_r = er;
    end
  endtask

  task automatic test_div_zero();
    int lat, bc;
    logic [W-1:0] pq, pr;
    pq = last_q;
    pr = last_r;
    run_op(32'd5, 32'd0, 1'b0, lat, bc);
    n_vec++;
    if (lat !== 1 || div_by_zero !== 1'b1) begin
      n_miss++;
      $display("FAIL dz_pulse: got lat=%0d dz=%b expected lat=1 dz=1", lat, div_by_zero);
    end
    n_vec++;
    if (quotient !== pq || remainder !== pr) begin
      n_miss++;
      $display("FAIL dz_hold: got q=%h r=%h expected q=%h r=%h", quotient, remainder, pq, pr);
    end
    step();
    n_vec++;
    if (done !== 1'b0 || div_by_zero !== 1'b0) begin
      n_miss++;
      $display("FAIL dz_width: got done=%b dz=%b expected 0 0", done, div_by_zero);
    end
  endtask

  task automatic test_overflow();
    logic [W-1:0] ys[2] = '{32'hFFFF_FFFF, 32'h1};
    int lat, bc;
    for (int i = 0; i < 2; i++) begin
      run_op(32'h8000_0000, ys[i], 1'b0, lat, bc);
      n_vec++;
      if (quotient !== 32'h8000_0000 || remainder !== 32'h0) begin
        n_miss++;
        $display("FAIL overflow%0d: got q=%h r=%h expected q=80000000 r=0",
                 i, quotient, remainder);
      end
    end
    last_q = 32'h8000_0000;
    last_r = 32'h0;
  endtask

  task automatic test_ignore_start();
    int lat;
    a     = 32'd1000;
    b     = 32'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    lat   = 0;
    repeat (5) begin step(); lat++; end
    a     = $urandom;
    b     = 32'd9;
    start = 1'b1;
    repeat (3) begin step(); lat++; end
    start = 1'b0;
    while (done !== 1'b1 && lat < 100) begin step(); lat++; end
    n_vec++;
    if (lat !== 34 || quotient !== 32'd333 || remainder !== 32'd1) begin
      n_miss++;
      $display("FAIL ignore_start: got lat=%0d q=%0d r=%0d expected lat=34 q=333 r=1",
               lat, quotient, remainder);
    end
    last_q = 32'd333;
    last_r = 32'd1;
  endtask

  task automatic test_reset_mid();
    int seen;
    a     = 32'd12345;
    b     = 32'd11;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (10) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_vec++;
    if ({quotient, remainder, busy, done, div_by_zero} !== {(2*W+3){1'b0}}) begin
      n_miss++;
      $display("FAIL reset_mid: got q=%h r=%h busy=%b done=%b dz=%b, expected all zero",
               quotient, remainder, busy, done, div_by_zero);
    end
    seen = 0;
    repeat (50) begin step(); if (done === 1'b1) seen++; end
    n_vec++;
    if (seen !== 0) begin n_miss++; $display("FAIL reset_no_done: got %0d done pulses expected 0", seen); end
    last_q = '0;
    last_r = '0;
  endtask

  task automatic test_random();
    logic [W-1:0] x, y, eq, er;
    int lat, bc, sel;
    for (int i = 0; i < 24; i++) begin
      x   = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0)      y = '0;
      else if (sel == 1) y = $urandom_range(1, 15);
      else if (sel == 2) y = -($urandom_range(1, 15));
      else               y = $urandom;
      if ($urandom_range(0, 7) == 0) x = 32'h8000_0000;
      model(x, y, 1'b0, eq, er);
      run_op(x, y, 1'b0, lat, bc);
      n_vec++;
      if (quotient !== eq || remainder !== er || div_by_zero !== (y == '0) ||
          lat !== ((y == '0) ? 1 : 34)) begin
        n_miss++;
        $display("FAIL random%0d a=%h b=%h: got q=%h r=%h dz=%b lat=%0d expected q=%h r=%h",
                 i, x, y, quotient, remainder, div_by_zero, lat, eq, er);
      end
      last_q = eq;
      last_r = er;
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] x, y, eq, er;
    int lat, bc;
    for (int i = 0; i < 4; i++) begin
      x = $urandom;
      y = $urandom_range(1, 1000);
      model(x, y, 1'b0, eq, er);
      run_op(x, y, 1'b1, lat, bc);
      n_vec++;
      if (quotient !== eq || remainder !== er || lat !== 34) begin
        n_miss++;
        $display("FAIL back_to_back%0d: got q=%h r=%h lat=%0d expected q=%h r=%h lat=34",
                 i, quotient, remainder, lat, eq, er);
      end
      last_q = eq;
      last_r = er;
    end
    start = 1'b0;
    repeat (3) step();
  endtask

`ifdef SEQ_DIVIDER_UNSIGNED_EN
  task automatic test_unsigned();
    logic [W-1:0] ys[2] = '{32'h10, 32'h2};
    logic [W-1:0] eq, er;
    int lat, bc;
    is_unsigned = 1'b1;
    for (int i = 0; i < 2; i++) begin
      model(32'hFFFF_FFFF, ys[i], 1'b1, eq, er);
      run_op(32'hFFFF_FFFF, ys[i], 1'b0, lat, bc);
      n_vec++;
      if (quotient !== eq || remainder !== er) begin
        n_miss++;
        $display("FAIL unsigned%0d: got q=%h r=%h expected q=%h r=%h",
                 i, quotient, remainder, eq, er);
      end
    end
    is_unsigned = 1'b0;
    run_op(32'hFFFF_FFFF, 32'h10, 1'b0, lat, bc);
    n_vec++;
    if (quotient !== 32'h0 || remainder !== 32'hFFFF_FFFF) begin
      n_miss++;
      $display("FAIL unsigned_off: got q=%h r=%h expected q=0 r=ffffffff", quotient, remainder);
    end
    last_q = 32'h0;
    last_r = 32'hFFFF_FFFF;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_signs();
    test_div_zero();
    test_overflow();
    test_ignore_start();
    test_reset_mid();
    test_random();
    test_back_to_back();
`ifdef SEQ_DIVIDER_UNSIGNED_EN
    test_unsigned();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
